// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded pointer crossing: synchronizes the remote pointer,
// decodes it to binary, reports the per-cycle advance and flags multi-bit Gray steps.
module gray_ptr_rx #(
    parameter int N           = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] gray_i,
    input  logic         clr_err_i,
    output logic [N-1:0] bin_o,
    output logic         valid_o,
    output logic [N-1:0] delta_o,
    output logic         step_err_o,
    output logic [15:0]  err_cnt_o
);

    localparam int FILL_MAX_I = SYNC_STAGES + 1;
    localparam int CW         = $clog2(FILL_MAX_I + 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(FILL_MAX_I);
    localparam logic [CW-1:0] FILL_PRE = CW'(SYNC_STAGES);

    logic [N-1:0]  sync_reg [SYNC_STAGES];
    logic [N-1:0]  g_s;
    logic [N-1:0]  g_p_reg;
    logic [N-1:0]  b_next;
    logic [N-1:0]  diff;
    logic          multi_bit;
    logic [N-1:0]  bin_reg;
    logic [N-1:0]  delta_reg;
    logic          step_err_reg;
    logic          valid_reg;
    logic [CW-1:0] fill_reg;
    logic [15:0]   err_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
            sync_reg[0] <= gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
    end

    assign g_s = sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign b_next[gi] = ^g_s[N-1:gi];
        end
    endgenerate

    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    assign diff      = g_s ^ g_p_reg;
    assign multi_bit = |(diff & (diff - N'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (fill_reg != FILL_MAX) fill_reg <= fill_reg + 1'b1;
            valid_reg <= (fill_reg >= FILL_PRE);
        end
    end

    // Delta and step check are gated by the already-raised valid so that both
    // operands of each compare are real post-reset samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g_p_reg      <= '0;
            bin_reg      <= '0;
            delta_reg    <= '0;
            step_err_reg <= 1'b0;
        end else begin
            g_p_reg      <= g_s;
            bin_reg      <= b_next;
            delta_reg    <= valid_reg ? (b_next - bin_reg) : '0;
            step_err_reg <= valid_reg & multi_bit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_err_i) begin
            err_cnt_reg <= '0;
        end else if (step_err_reg && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign bin_o      = bin_reg;
    assign valid_o    = valid_reg;
    assign delta_o    = delta_reg;
    assign step_err_o = step_err_reg;
    assign err_cnt_o  = err_cnt_reg;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Bench for gray_ptr_rx (N=4, SYNC_STAGES=2): vector table, hand sequences and
// randomized stimulus against a history-based reference model.
module tb_gray_ptr_rx;

    localparam int N = 4;
    localparam int S = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clr_err_i = 1'b0;
    logic [N-1:0]  gray_i = '0;
    logic [N-1:0]  bin_o;
    logic          valid_o;
    logic [N-1:0]  delta_o;
    logic          step_err_o;
    logic [15:0]   err_cnt_o;

    gray_ptr_rx #(.N(N), .SYNC_STAGES(S)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .gray_i     (gray_i),
        .clr_err_i  (clr_err_i),
        .bin_o      (bin_o),
        .valid_o    (valid_o),
        .delta_o    (delta_o),
        .step_err_o (step_err_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: raw input history since reset, decoded on demand.
    logic [N-1:0] hist[$];
    int           since_rst = 0;
    logic [N-1:0] m_bin = '0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_delta = '0;
    logic         m_step = 1'b0;
    logic [15:0]  m_err = '0;

    typedef struct {
        logic [N-1:0] gray;
        logic         rst;
        logic         clr;
        logic [N-1:0] bin;
        logic         valid;
        logic [N-1:0] delta;
        logic         step;
        logic [15:0]  err;
    } vec_t;

    function automatic logic [N-1:0] to_gray(int v);
        logic [N-1:0] b;
        b = N'(v);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: find the binary value whose Gray code matches.
    function automatic logic [N-1:0] g2b(logic [N-1:0] g);
        for (int v = 0; v < (1 << N); v++) begin
            if (to_gray(v) == g) return N'(v);
        end
        return '0;
    endfunction

    function automatic int popcnt(logic [N-1:0] x);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(logic [N-1:0] g, logic r, logic c);
        logic [N-1:0] a, p;
        @(negedge clk_i);
        gray_i    = g;
        rst_i     = r;
        clr_err_i = c;
        @(posedge clk_i);
        if (r) begin
            hist.delete();
            since_rst = 0;
            m_bin = '0; m_valid = 1'b0; m_delta = '0; m_step = 1'b0; m_err = '0;
        end else begin
            if (c) m_err = '0;
            else if (m_step && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            hist.push_back(g);
            if (hist.size() > 8) void'(hist.pop_front());
            if (since_rst < 100) since_rst++;
            m_valid = (since_rst >= S + 1);
            m_bin   = m_valid ? g2b(hist[hist.size()-1-S]) : '0;
            if (since_rst >= S + 2) begin
                a = hist[hist.size()-1-S];
                p = hist[hist.size()-2-S];
                m_delta = g2b(a) - g2b(p);
                m_step  = (popcnt(a ^ p) > 1);
            end else begin
                m_delta = '0;
                m_step  = 1'b0;
            end
        end
        #1;
        check("bin", 32'(bin_o), 32'(m_bin));
        check("valid", 32'(valid_o), 32'(m_valid));
        check("delta", 32'(delta_o), 32'(m_delta));
        check("step_err", 32'(step_err_o), 32'(m_step));
        check("err_cnt", 32'(err_cnt_o), 32'(m_err));
    endtask

    vec_t vecs[16];
    int   wait_cnt;
    logic [N-1:0] cur_bin;

    initial begin
        // Reset/fill followed by a multi-bit jump from bin 3 (Gray 0010) to Gray 0111.
        vecs[0]  = '{4'b0110, 1, 0, 4'h0, 0, 4'h0, 0, 16'd0};
        vecs[1]  = '{4'b0110, 1, 0, 4'h0, 0, 4'h0, 0, 16'd0};
        vecs[2]  = '{4'b0110, 1, 0, 4'h0, 0, 4'h0, 0, 16'd0};
        vecs[3]  = '{4'b0110, 0, 0, 4'h0, 0, 4'h0, 0, 16'd0};
        vecs[4]  = '{4'b0110, 0, 0, 4'h0, 0, 4'h0, 0, 16'd0};
        vecs[5]  = '{4'b0110, 0, 0, 4'h4, 1, 4'h0, 0, 16'd0};
        vecs[6]  = '{4'b0110, 0, 0, 4'h4, 1, 4'h0, 0, 16'd0};
        vecs[7]  = '{4'b0010, 0, 0, 4'h4, 1, 4'h0, 0, 16'd0};
        vecs[8]  = '{4'b0010, 0, 0, 4'h4, 1, 4'h0, 0, 16'd0};
        vecs[9]  = '{4'b0010, 0, 0, 4'h3, 1, 4'hF, 0, 16'd0};
        vecs[10] = '{4'b0010, 0, 0, 4'h3, 1, 4'h0, 0, 16'd0};
        vecs[11] = '{4'b0111, 0, 0, 4'h3, 1, 4'h0, 0, 16'd0};
        vecs[12] = '{4'b0111, 0, 0, 4'h3, 1, 4'h0, 0, 16'd0};
        vecs[13] = '{4'b0111, 0, 0, 4'h5, 1, 4'h2, 1, 16'd0};
        vecs[14] = '{4'b0111, 0, 0, 4'h5, 1, 4'h0, 0, 16'd1};
        vecs[15] = '{4'b0111, 0, 0, 4'h5, 1, 4'h0, 0, 16'd1};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].gray, vecs[i].rst, vecs[i].clr);
            check($sformatf("vec%0d_bin", i), 32'(bin_o), 32'(vecs[i].bin));
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].valid));
            check($sformatf("vec%0d_delta", i), 32'(delta_o), 32'(vecs[i].delta));
            check($sformatf("vec%0d_step", i), 32'(step_err_o), 32'(vecs[i].step));
            check($sformatf("vec%0d_err", i), 32'(err_cnt_o), 32'(vecs[i].err));
        end

        // Up-count with wrap, twice; fresh reset so err_cnt starts at 0.
        step('0, 1'b1, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) step(to_gray(i), 1'b0, 1'b0);
        end
        check("upcount_err_cnt", 32'(err_cnt_o), 32'd0);
        check("wrap_delta", 32'(delta_o), 32'd1);

        // Down-count.
        for (int i = 0; i < 16; i++) step(to_gray(15 - i), 1'b0, 1'b0);
        check("down_delta", 32'(delta_o), 32'hF);

        // Reset mid-stream during an up-count.
        for (int i = 0; i < 5; i++) step(to_gray(i), 1'b0, 1'b0);
        step(to_gray(5), 1'b1, 1'b0);
        check("midrst_bin", 32'(bin_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_delta", 32'(delta_o), 32'd0);
        check("midrst_step", 32'(step_err_o), 32'd0);
        check("midrst_err", 32'(err_cnt_o), 32'd0);
        wait_cnt = 0;
        for (int i = 6; i < 16 && !valid_o; i++) begin
            step(to_gray(i), 1'b0, 1'b0);
            wait_cnt++;
        end
        check("midrst_valid_latency", 32'(wait_cnt), 32'd3);
        for (int i = 0; i < 4; i++) step(to_gray(9 + i), 1'b0, 1'b0);

        // Randomized: mostly single steps, occasional jumps, clears and resets.
        cur_bin = '0;
        for (int i = 0; i < 600; i++) begin
            int sel = int'($urandom_range(0, 15));
            if (sel < 10) cur_bin = cur_bin + N'($urandom_range(0, 2)) - N'(1);
            else if (sel < 14) cur_bin = N'($urandom);
            step(to_gray(int'(cur_bin)), ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
        end

        // Error-counter saturation, then clear coincident with a pulse.
        step('0, 1'b1, 1'b0);
        for (int i = 0; i < 65600; i++) step((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0, 1'b0);
        check("sat_err_cnt", 32'(err_cnt_o), 32'hFFFF);
        check("sat_pulse_present", 32'(step_err_o), 32'd1);
        step(4'b0000, 1'b0, 1'b1);
        check("clr_priority", 32'(err_cnt_o), 32'd0);
        step(4'b0011, 1'b0, 1'b0);
        check("count_after_clr", 32'(err_cnt_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Receive side of the Gray-coded pointer path. Takes an N-bit Gray-coded pointer arriving asynchronously from another clock domain, synchronizes it into the local clock, decodes it to binary and reports the per-cycle advance. It also flags any update that changes more than one Gray bit. The block sits at the read/consumer end of cross-domain FIFOs and counters, paired with the Gray encoder on the producing side.

## Interface

**Parameters**
- `N`, default 20: pointer width in bits (N ≥ 2).
- `SYNC_STAGES`, default 2: synchronizer flop depth (≥ 2).

**Ports**
- `clk_i`, in, 1: local clock; all flops rising-edge.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `gray_i`, in, N: Gray-coded pointer from the remote domain; asynchronous to `clk_i`.
- `clr_err_i`, in, 1: clears `err_cnt_o`.
- `bin_o`, out, N: decoded binary pointer (registered).
- `valid_o`, out, 1: high once the pipeline holds post-reset samples.
- `delta_o`, out, N: `bin_o` minus the previous `bin_o`, modulo 2^N (registered).
- `step_err_o`, out, 1: one-cycle pulse when the synchronized Gray value changed in more than one bit.
- `err_cnt_o`, out, 16: saturating count of `step_err_o` pulses.

## Operation

**Synchronizer**
- `SYNC_STAGES` flops in series sample `gray_i`; the last stage is `g_s`.
- A previous-value register `g_p` captures `g_s` every cycle.

**Decode**
- `b[N-1] = g_s[N-1]`.
- `b[i] = b[i+1] ^ g_s[i]` for i = N-2 down to 0.
- `bin_o` registers `b`.

**Delta**
- `delta_o` registers `b - bin_o`, truncated to N bits.
- Examples:
  - Forward step gives delta 1.
  - Backward step gives 2^N−1.
  - No change gives 0.

**Step check**
- `step_err_o` registers `popcount(g_s ^ g_p) > 1`.
- The check is qualified by the fill counter: it is suppressed until the cycle after `valid_o` first rises, so the first compare is between two real samples.

**Fill counter**
- Counts 0 to `SYNC_STAGES`+1 after reset, then holds.
- `valid_o` is high when the counter equals `SYNC_STAGES`+1.
- While `valid_o` is low, `delta_o` is 0 and `step_err_o` is 0.

**Error counter**
- Increments on `step_err_o` and saturates at 0xFFFF.
- If `clr_err_i` and `step_err_o` are both high in the same cycle, the clear wins and the count becomes 0; that pulse is not counted.

**Reset values**
- All synchronizer stages, `g_p`, `bin_o`, `delta_o`, `step_err_o`, `err_cnt_o` and the fill counter are 0.
- `valid_o` is 0.

**Reset mid-operation**
- Any cycle with `rst_i` high forces all state to the reset values on that edge.
- Fill restarts and `valid_o` drops the following cycle.

**Wrap-around**
- Going from Gray(2^N−1) = 1 followed by zeros to Gray(0) = 0 is a single-bit change.
- It gives `delta_o` = 1 and no error.

**Stuck input**
- A constant `gray_i` gives `delta_o` = 0 and no error.

## Timing

- **Latency:** a change on `gray_i` captured at edge k appears in `g_s` after edge k+`SYNC_STAGES`−1. It appears in `bin_o`, `delta_o` and `step_err_o` after edge k+`SYNC_STAGES`, i.e. `SYNC_STAGES`+1 cycles from input change to output, with all three aligned in the same cycle.
- **First valid:** `valid_o` rises on the `SYNC_STAGES`+1-th edge after the edge on which `rst_i` was last sampled high.
- **Throughput:** one pointer sample per cycle; no handshake and no back-pressure.
- **Pulse width:** `step_err_o` is exactly one cycle wide per offending transition. Consecutive bad transitions give consecutive pulses.
- **Remote rate:** the remote side must change `gray_i` at most once per local cycle for `delta_o` to be meaningful. Faster updates are allowed but are reported as step errors or larger deltas; the block does not filter them.

## Test plan

All scenarios use N = 4 and SYNC_STAGES = 2 unless stated.

1. **Reset and fill:** assert `rst_i` 3 cycles with `gray_i` = 4'b0110, then release.
   - `valid_o` = 0 for 2 edges and rises on the 3rd.
   - `bin_o` = 4'h4.
   - `delta_o` = 0 and `step_err_o` = 0 throughout.
2. **Up-count with wrap:** drive `gray_i` = Gray(i) for i = 0..15 twice, one value per cycle.
   - Each `bin_o` equals i, 3 cycles later.
   - `delta_o` = 1 every valid cycle, including 15→0.
   - `step_err_o` never fires.
   - `err_cnt_o` = 0.
3. **Down-count:** drive Gray(15−i) for i = 0..15.
   - `delta_o` = 4'hF each step.
   - No step error.
4. **Multi-bit jump:** with `bin_o` = 4'h3 (Gray 4'b0010), drive Gray 4'b0111.
   - `step_err_o` pulses exactly once.
   - `err_cnt_o` = 1.
   - `bin_o` = 4'h5.
   - `delta_o` = 4'h2.
5. **Error-counter saturation and clear priority:** force `err_cnt_o` toward 0xFFFF by alternating 4'b0000/4'b0011 for 70000 cycles; it stops at 0xFFFF. Then assert `clr_err_i` coincident with a pulse; next `err_cnt_o` = 0.
6. **Reset mid-stream:** assert `rst_i` for 1 cycle during scenario 2.
   - All outputs read 0 the next cycle.
   - `valid_o` returns 3 cycles after release.
   - No spurious `step_err_o` on the first post-reset compare.
